// File: rtl/wallace_mult_pipe_if.sv
// wallace_mult_pipe_if
// Operand/product handshake bundle for wallace_mult_pipe.
//   master : operand issuer and result consumer (drives in_*, out_ready)
//   slave  : the multiplier (drives in_ready, out_valid, out_p)
// Signals:
//   in_valid/in_ready    operand pair handshake
//   in_signed            1 = two's complement operands, 0 = unsigned
//   in_a, in_b           WIDTH-bit operands
//   out_valid/out_ready  product handshake
//   out_p                2*WIDTH-bit product (or running sum)
//   acc_clr              only with WMUL_ACC_EN: restart the accumulator
// Optional feature macro: WMUL_ACC_EN
interface wallace_mult_pipe_if #(
  parameter int WIDTH = 16
);
  logic               in_valid;
  logic               in_ready;
  logic               in_signed;
  logic [WIDTH-1:0]   in_a;
  logic [WIDTH-1:0]   in_b;
  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH-1:0] out_p;
`ifdef WMUL_ACC_EN
  logic               acc_clr;
`endif

  modport master (
    output in_valid, in_signed, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_p
`ifdef WMUL_ACC_EN
    , output acc_clr
`endif
  );

  modport slave (
    input  in_valid, in_signed, in_a, in_b, out_ready,
    output in_ready, out_valid, out_p
`ifdef WMUL_ACC_EN
    , input acc_clr
`endif
  );
endinterface

// File: rtl/wallace_mult_pipe.sv
// wallace_mult_pipe
// Three-stage pipelined Wallace-tree multiplier, WIDTH x WIDTH -> 2*WIDTH,
// with per-transaction signed/unsigned mode and a valid/ready handshake.
//   S1: partial-product rows (Baugh-Wooley rows in signed mode)
//   S2: carry-save pair from the 3:2 compressor tree
//   S3: carry-propagate sum, presented on out_p
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    wallace_mult_pipe_if.slave (operand and product handshakes)
// Parameter: WIDTH (4..32), operand width.
// Optional feature macro: WMUL_ACC_EN -- adds acc_clr and an accumulator so
// out_p carries the running sum of products instead of the bare product.
module wallace_mult_pipe #(
  parameter int WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  wallace_mult_pipe_if.slave   bus
);
  localparam int P = 2 * WIDTH;
  // Enough 3:2 levels to bring 32 rows down to 2 (needs 8).
  localparam int LEVELS = 10;
  localparam logic [WIDTH-1:0] MSB_MASK = {1'b1, {(WIDTH-1){1'b0}}};
  // Baugh-Wooley correction: 2^WIDTH + 2^(2*WIDTH-1).
  localparam logic [P-1:0] BW_CORR = {1'b1, {(WIDTH-2){1'b0}}, 1'b1, {WIDTH{1'b0}}};

  logic adv;

  logic         s1_valid;
  logic [P-1:0] s1_pp [WIDTH];
  logic         s2_valid;
  logic [P-1:0] s2_sum;
  logic [P-1:0] s2_carry;
  logic         s3_valid;
  logic [P-1:0] s3_p;

  logic [P-1:0] pp_next [WIDTH];
  logic [P-1:0] csa_sum;
  logic [P-1:0] csa_carry;
  logic [P-1:0] final_sum;

  // The whole pipeline moves together; it only stalls when a finished
  // product is sitting at the output and nobody takes it.
  assign adv          = !s3_valid || bus.out_ready;
  assign bus.in_ready = adv;
  assign bus.out_valid = s3_valid;
  assign bus.out_p     = s3_p;

  // Partial-product rows. In signed mode the sign-weighted cross terms are
  // complemented (row WIDTH-1 except its MSB, and the MSB of every other
  // row) and the correction constant rides in the free bits of row 0, so the
  // signed flag is fully folded into the S1 rows and need not travel further.
  always_comb begin
    logic [WIDTH-1:0] row_bits;
    logic [WIDTH-1:0] flip;
    for (int i = 0; i < WIDTH; i++) begin
      row_bits = bus.in_a & {WIDTH{bus.in_b[i]}};
      flip     = (i == WIDTH - 1) ? ~MSB_MASK : MSB_MASK;
      if (bus.in_signed) begin
        row_bits = row_bits ^ flip;
      end
      pp_next[i] = P'(row_bits) << i;
    end
    if (bus.in_signed) begin
      pp_next[0] = pp_next[0] | BW_CORR;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      for (int i = 0; i < WIDTH; i++) begin
        s1_pp[i] <= '0;
      end
    end else if (adv) begin
      s1_valid <= bus.in_valid;
      if (bus.in_valid) begin
        for (int i = 0; i < WIDTH; i++) begin
          s1_pp[i] <= pp_next[i];
        end
      end
    end
  end

  // Wallace reduction over a fixed slot array: each level compresses every
  // group of three slots into a sum and a shifted carry, and moves leftover
  // slots down behind them. Live rows stay packed at the low slots, so the
  // unused slots are constant zero and fold away; after LEVELS levels only
  // slots 0 and 1 can be non-zero.
  always_comb begin
    logic [P-1:0] cur [WIDTH];
    logic [P-1:0] nxt [WIDTH];
    for (int i = 0; i < WIDTH; i++) begin
      cur[i] = s1_pp[i];
    end
    for (int lvl = 0; lvl < LEVELS; lvl++) begin
      for (int i = 0; i < WIDTH; i++) begin
        nxt[i] = '0;
      end
      for (int g = 0; g < WIDTH / 3; g++) begin
        nxt[2*g]   = cur[3*g] ^ cur[3*g+1] ^ cur[3*g+2];
        nxt[2*g+1] = ((cur[3*g] & cur[3*g+1]) |
                      (cur[3*g] & cur[3*g+2]) |
                      (cur[3*g+1] & cur[3*g+2])) << 1;
      end
      for (int k = 3 * (WIDTH / 3); k < WIDTH; k++) begin
        nxt[k - WIDTH/3] = cur[k];
      end
      for (int i = 0; i < WIDTH; i++) begin
        cur[i] = nxt[i];
      end
    end
    csa_sum   = cur[0];
    csa_carry = cur[1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      s2_sum   <= '0;
      s2_carry <= '0;
    end else if (adv) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_sum   <= csa_sum;
        s2_carry <= csa_carry;
      end
    end
  end

  assign final_sum = s2_sum + s2_carry;

`ifdef WMUL_ACC_EN
  logic         s1_clr;
  logic         s2_clr;
  logic [P-1:0] acc_q;
  logic [P-1:0] acc_base;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_clr <= 1'b0;
      s2_clr <= 1'b0;
    end else if (adv) begin
      s1_clr <= bus.in_valid & bus.acc_clr;
      s2_clr <= s1_clr;
    end
  end

  // When S3 loads while holding a valid result, that result is being
  // delivered on this same edge, so it is the accumulator value the new
  // transaction must build on (acc_q has not caught up yet).
  always_comb begin
    acc_base = s3_valid ? s3_p : acc_q;
    if (s2_clr) begin
      acc_base = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
    end else if (s3_valid && bus.out_ready) begin
      acc_q <= s3_p;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s3_valid <= 1'b0;
      s3_p     <= '0;
    end else if (adv) begin
      s3_valid <= s2_valid;
      if (s2_valid) begin
        s3_p <= acc_base + final_sum;
      end
    end
  end
`else
  // Bubbles leave out_p untouched; only real products overwrite it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s3_valid <= 1'b0;
      s3_p     <= '0;
    end else if (adv) begin
      s3_valid <= s2_valid;
      if (s2_valid) begin
        s3_p <= final_sum;
      end
    end
  end
`endif

endmodule

// File: tb/tb_wallace_mult_pipe.sv
// tb_wallace_mult_pipe
// Self-checking bench for wallace_mult_pipe at WIDTH=16: directed vector
// table, backpressure, asynchronous reset mid-stream, randomized traffic
// against an arithmetic reference model, and (with WMUL_ACC_EN) the
// accumulate sequence.
module tb_wallace_mult_pipe;
  localparam int WIDTH = 16;
  localparam int P = 2 * WIDTH;

  typedef struct {
    string            name;
    logic             sgn;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [P-1:0]     exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  wallace_mult_pipe_if #(.WIDTH(WIDTH)) bus ();

  wallace_mult_pipe #(.WIDTH(WIDTH)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int n_compared = 0;
  int n_mismatched = 0;
  logic [P-1:0] exp_q [$];
  logic [P-1:0] got_q [$];
  logic [P-1:0] model_acc = '0;

  // Reference: sign- or zero-extend, multiply in 64 bits, keep 2*WIDTH bits.
  function automatic logic [P-1:0] ref_product(input logic s,
                                               input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b);
    longint ea;
    longint eb;
    longint pr;
    ea = s ? longint'($signed(a)) : longint'(a);
    eb = s ? longint'($signed(b)) : longint'(b);
    pr = ea * eb;
    return pr[P-1:0];
  endfunction

  task automatic checkOutput(input string name, input logic [P-1:0] actual,
                             input logic [P-1:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic checkGot(input string name, input int idx, input logic [P-1:0] expected);
    if (got_q.size() > idx) begin
      checkOutput(name, got_q[idx], expected);
    end else begin
      n_compared++;
      n_mismatched++;
      $display("[TB] FAIL %s: got no product at position %0d, expected %0h", name, idx, expected);
    end
  endtask

  // Drive one cycle from a negedge: set inputs, score both handshakes for
  // the coming rising edge, then return at the next negedge.
  task automatic applyStimulus(input logic v, input logic s,
                               input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                               input logic clr, input logic ordy,
                               output logic accepted);
    logic [P-1:0] p;
    bus.in_valid  = v;
    bus.in_signed = s;
    bus.in_a      = a;
    bus.in_b      = b;
    bus.out_ready = ordy;
`ifdef WMUL_ACC_EN
    bus.acc_clr   = clr;
`endif
    #1;
    accepted = v && bus.in_ready;
    if (bus.out_valid && ordy) begin
      got_q.push_back(bus.out_p);
      if (exp_q.size() == 0) begin
        n_compared++;
        n_mismatched++;
        $display("[TB] FAIL spurious_output: got %0h, expected no output", bus.out_p);
      end else begin
        checkOutput("product", bus.out_p, exp_q.pop_front());
      end
    end
    if (accepted) begin
      p = ref_product(s, a, b);
      model_acc = clr ? p : model_acc + p;
`ifdef WMUL_ACC_EN
      exp_q.push_back(model_acc);
`else
      exp_q.push_back(p);
`endif
    end
    @(negedge clk);
  endtask

  task automatic idle(input logic ordy);
    logic acc;
    applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, ordy, acc);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < 40) begin
      idle(1'b1);
      n++;
    end
    checkOutput("drain_left", P'(exp_q.size()), '0);
    repeat (4) idle(1'b1);
  endtask

  vec_t table_v [8];
  vec_t bp_v [4];

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic acc;
    int lat;

    table_v[0] = '{"u_ffff_ffff", 1'b0, 16'hFFFF, 16'hFFFF, 32'hFFFE0001};
    table_v[1] = '{"s_ffff_ffff", 1'b1, 16'hFFFF, 16'hFFFF, 32'h00000001};
    table_v[2] = '{"s_8000_7fff", 1'b1, 16'h8000, 16'h7FFF, 32'hC0008000};
    table_v[3] = '{"s_8000_8000", 1'b1, 16'h8000, 16'h8000, 32'h40000000};
    table_v[4] = '{"u_8000_8000", 1'b0, 16'h8000, 16'h8000, 32'h40000000};
    table_v[5] = '{"s_7fff_7fff", 1'b1, 16'h7FFF, 16'h7FFF, 32'h3FFF0001};
    table_v[6] = '{"s_fffe_0003", 1'b1, 16'hFFFE, 16'h0003, 32'hFFFFFFFA};
    table_v[7] = '{"u_1234_5678", 1'b0, 16'h1234, 16'h5678, 32'h06260060};

    bp_v[0] = '{"bp0", 1'b0, 16'h00FF, 16'h0101, 32'h0000FFFF};
    bp_v[1] = '{"bp1", 1'b1, 16'hFFFD, 16'h0007, 32'hFFFFFFEB};
    bp_v[2] = '{"bp2", 1'b0, 16'hFFFF, 16'h0002, 32'h0001FFFE};
    bp_v[3] = '{"bp3", 1'b1, 16'h8000, 16'hFFFF, 32'h00008000};

    bus.in_valid  = 1'b0;
    bus.in_signed = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.out_ready = 1'b0;
`ifdef WMUL_ACC_EN
    bus.acc_clr   = 1'b0;
`endif
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkOutput("reset_out_valid", P'(bus.out_valid), '0);
    checkOutput("reset_out_p", bus.out_p, '0);
    checkOutput("reset_in_ready", P'(bus.in_ready), P'(1));
    @(negedge clk);

    // Directed vectors, one at a time, with latency measurement.
    for (int i = 0; i < 8; i++) begin
      got_q.delete();
      applyStimulus(1'b1, table_v[i].sgn, table_v[i].a, table_v[i].b, 1'b1, 1'b1, acc);
      checkOutput("table_accept", P'(acc), P'(1));
      lat = 1;
      while (!bus.out_valid && lat < 10) begin
        idle(1'b0);
        lat++;
      end
      checkOutput("table_latency", P'(lat), P'(3));
      idle(1'b1);
      checkGot(table_v[i].name, 0, table_v[i].exp);
    end
    drain();

    // Backpressure: three fill the pipe, the fourth is stalled.
    got_q.delete();
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b1, bp_v[k].sgn, bp_v[k].a, bp_v[k].b, 1'b1, 1'b0, acc);
      checkOutput("bp_fill_accept", P'(acc), P'(1));
    end
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b1, bp_v[3].sgn, bp_v[3].a, bp_v[3].b, 1'b1, 1'b0, acc);
      checkOutput("bp_stalled_accept", P'(acc), '0);
      checkOutput("bp_hold_valid", P'(bus.out_valid), P'(1));
      checkOutput("bp_hold_out_p", bus.out_p, bp_v[0].exp);
    end
    applyStimulus(1'b1, bp_v[3].sgn, bp_v[3].a, bp_v[3].b, 1'b1, 1'b1, acc);
    checkOutput("bp_release_accept", P'(acc), P'(1));
    drain();
    checkOutput("bp_count", P'(got_q.size()), P'(4));
    for (int k = 0; k < 4; k++) begin
      checkGot(bp_v[k].name, k, bp_v[k].exp);
    end

    // Asynchronous reset with three transactions in flight.
    got_q.delete();
    applyStimulus(1'b1, 1'b0, 16'h0010, 16'h0010, 1'b1, 1'b1, acc);
    applyStimulus(1'b1, 1'b1, 16'hFFFF, 16'h0005, 1'b1, 1'b1, acc);
    applyStimulus(1'b1, 1'b0, 16'h0020, 16'h0020, 1'b1, 1'b1, acc);
    checkOutput("prereset_valid", P'(bus.out_valid), P'(1));
    bus.in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async_reset_valid", P'(bus.out_valid), '0);
    checkOutput("async_reset_out_p", bus.out_p, '0);
    exp_q.delete();
    model_acc = '0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) idle(1'b1);
    checkOutput("post_reset_quiet", P'(got_q.size()), '0);
    applyStimulus(1'b1, 1'b0, 16'h0003, 16'h0005, 1'b1, 1'b1, acc);
    drain();
    checkOutput("post_reset_count", P'(got_q.size()), P'(1));
    checkGot("post_reset_product", 0, 32'h0000000F);

    // Randomized traffic; an unaccepted pair is held until it is taken.
    begin
      logic v, s, clr, ordy, pend;
      logic [WIDTH-1:0] a, b;
      int cnt, cyc;
      cnt = 0;
      cyc = 0;
      pend = 1'b0;
      v = 1'b0; s = 1'b0; clr = 1'b0; a = '0; b = '0;
      while (cnt < 1000 && cyc < 8000) begin
        if (!pend) begin
          v   = ($urandom_range(0, 3) != 0);
          s   = $urandom_range(0, 1) != 0;
          a   = WIDTH'($urandom);
          b   = WIDTH'($urandom);
          clr = ($urandom_range(0, 3) == 0);
          if ($urandom_range(0, 9) == 0) a = 16'h8000;
          if ($urandom_range(0, 9) == 0) b = 16'h8000;
        end
        ordy = ($urandom_range(0, 2) != 0);
        applyStimulus(v, s, a, b, clr, ordy, acc);
        pend = v && !acc;
        if (acc) cnt++;
        cyc++;
      end
      checkOutput("random_accepted", P'(cnt), P'(1000));
      drain();
    end

`ifdef WMUL_ACC_EN
    // Accumulate: 12, 12+30, 42+4, then a cleared 1.
    got_q.delete();
    applyStimulus(1'b1, 1'b0, 16'd3, 16'd4, 1'b1, 1'b1, acc);
    applyStimulus(1'b1, 1'b0, 16'd5, 16'd6, 1'b0, 1'b1, acc);
    applyStimulus(1'b1, 1'b0, 16'd2, 16'd2, 1'b0, 1'b1, acc);
    applyStimulus(1'b1, 1'b0, 16'd1, 16'd1, 1'b1, 1'b1, acc);
    drain();
    checkGot("acc_first", 0, 32'd12);
    checkGot("acc_second", 1, 32'd42);
    checkGot("acc_third", 2, 32'd46);
    checkGot("acc_cleared", 3, 32'd1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end
endmodule

// File: doc/wallace_mult_pipe.md
Name: wallace_mult_pipe

Overview:
- Parametrised, pipelined Wallace-tree multiplier; successor to the 16x16 combinational CSA-tree multiplier.
- Accepts one WIDTH x WIDTH operand pair per cycle through a valid/ready handshake and returns the 2*WIDTH-bit product after a fixed 3-cycle latency.
- Supports per-transaction signed (two's complement) or unsigned mode.
- Sits between the operand-issue logic and the result writeback in the arithmetic datapath.

Parameters:
- WIDTH, 16, operand width in bits; legal range 4..32; product is 2*WIDTH bits.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operand pair valid
- in_ready  out  1  block can accept an operand pair this cycle
- in_signed  in  1  1 = treat A and B as two's complement; 0 = unsigned
- in_a  in  WIDTH  multiplicand
- in_b  in  WIDTH  multiplier
- out_valid  out  1  product valid
- out_ready  in  1  consumer accepts the product
- out_p  out  2*WIDTH  product, or accumulated sum when WMUL_ACC_EN is defined

Behaviour:
- Interface: one clock, clk. rst_n is asynchronous assert, active-low.
- Reset: all stage valid bits are 0; out_valid=0; out_p=0; in_ready=1 once rst_n deasserts. Any transactions in flight are dropped with no output.
- Pipeline structure:
  - S1 registers the partial products: WIDTH rows of 2*WIDTH bits. In signed mode, rows use Baugh-Wooley complementing plus the correction constant.
  - S2 registers the two carry-save operands from the 3:2 CSA reduction tree.
  - S3 registers the final carry-propagate sum into out_p.
- Latency: 3 cycles from an accepted input to out_valid, provided there is no backpressure.
- Global advance: adv = !out_valid || out_ready. in_ready = adv, which is combinational from out_valid and out_ready.
- When adv=1, every stage loads from its predecessor, including its valid bit and its signed flag.
- When adv=0, every stage holds; out_p and out_valid stay stable until accepted.
- Input handshake: a transfer occurs when in_valid && in_ready. When in_valid=0 and adv=1, a bubble (valid=0) enters S1.
- Output handshake: a transfer occurs when out_valid && out_ready.
- Throughput: 1 product per cycle when out_ready is held high.
- Simultaneous accept and deliver in the same cycle is legal and loses no data.
- Arithmetic: the result is mod 2^(2*WIDTH).
  - Unsigned: the exact product always fits.
  - Signed: the exact product always fits, including (-2^(W-1))*(-2^(W-1)) = 2^(2W-2).
- The signed flag is captured per transaction. Mixing signed and unsigned back-to-back must not corrupt neighbouring results.
- Bubbles never change out_p.

Optional Feature:
- Macro: WMUL_ACC_EN.
- When defined:
  - Adds input port acc_clr (1 bit) and a 2*WIDTH-bit accumulator register, reset to 0.
  - S3 computes acc + (S2 sum). out_p presents that value. The accumulator updates to that value on each output transfer.
  - acc_clr=1 sampled with an input transfer marks that transaction. Its output becomes the bare product, and the accumulator restarts from it.
  - Accumulation wraps mod 2^(2*WIDTH).
- When undefined: there is no acc_clr port and no accumulator; out_p is the plain product.

Test Plan:
- WIDTH=16, unsigned A=FFFF, B=FFFF -> out_p=FFFE0001 with out_valid exactly 3 cycles after acceptance.
- Signed FFFF*FFFF -> 00000001. Signed 8000*7FFF -> C0008000. Signed 8000*8000 -> 40000000. Unsigned 8000*8000 -> 40000000.
- Issue 4 pairs back-to-back with out_ready=0 -> in_ready drops after the pipeline fills. Then raise out_ready -> all 4 products emerge in order, out_p is held stable while stalled, and no product is lost or duplicated.
- 1000 random pairs with random in_signed, in_valid and out_ready -> every product matches the reference model in order. Also run WIDTH=8 and WIDTH=32 builds.
- Assert rst_n low mid-stream with 3 in flight -> out_valid=0 and out_p=0 immediately, asynchronously. After release, nothing stale appears; the next input is returned correctly.
- WMUL_ACC_EN defined: 3*4 with acc_clr=1, then 5*6, then 2*2 -> out_p = 12, 42, 46. A subsequent 1*1 with acc_clr=1 -> 1.
